add_share_arb: RTL

Shares the single 8-bit adder datapath between two independent requesters on the Tiny Tapeout tile. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester at a time in round-robin order, registers its operands, and executes the add. It then holds the 9-bit result on a shared response bus until the granted requester accepts it. The block sits between the pin-mapping logic (`ui_in`/`uio_in` decoding) and `uo_out`/`uio_out` driving in the top-level `tt_um_*` wrapper.

---
 rtl/add_share_arb_if.sv | 39 +++
 rtl/add_share_arb.sv | 112 +++++++++++
 2 files changed

// File: rtl/add_share_arb_if.sv
// Handshake bundle between two adder requesters and the shared adder arbiter.
//
// Signals:
//   req_valid[1:0]  requester i presents operands
//   req_ready[1:0]  requester i's operands are accepted this cycle (one-hot)
//   req_a0/req_b0   requester 0 operands
//   req_a1/req_b1   requester 1 operands
//   resp_valid[1:0] result for requester i is on resp_sum
//   resp_ready[1:0] requester i accepts its result
//   resp_sum        WIDTH+1 bit sum, MSB is the carry
//   resp_id         owner of the current or last result
//   busy            arbiter is not idle
//
// Modports: slave = arbiter side, master = requester/response side.
interface add_share_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [WIDTH:0]   resp_sum;
    logic             resp_id;
    logic             busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
        output req_ready, resp_valid, resp_sum, resp_id, busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
        input  req_ready, resp_valid, resp_sum, resp_id, busy
    );
endinterface

// File: rtl/add_share_arb.sv
// Shares one WIDTH-bit adder between two requesters. One requester is granted
// at a time (round-robin on ties), its operands are registered, added at full
// WIDTH+1 precision, and the sum is held on the response bus until the owner
// accepts it.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  add_share_arb_if.slave: request/response handshakes, sum, id, busy
//
// Build option:
//   ADDSHARE_FIXED_PRIO_EN  when defined, requester 0 always wins ties;
//                           last_grant is still tracked but not used.
module add_share_arb #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    add_share_arb_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             id_q, id_d;
    logic             resp_id_q, resp_id_d;
    logic             last_grant_q, last_grant_d;
    logic             win;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;

    // Winner among valid requesters; only meaningful when some bit is set.
    always_comb begin
        win = 1'b0;
`ifdef ADDSHARE_FIXED_PRIO_EN
        win = ~bus.req_valid[0];
`else
        if (bus.req_valid == 2'b11) begin
            win = ~last_grant_q;
        end else begin
            win = ~bus.req_valid[0];
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        id_d         = id_q;
        resp_id_d    = resp_id_q;
        last_grant_d = last_grant_q;
        req_ready    = 2'b00;
        resp_valid   = 2'b00;

        unique case (state_q)
            StIdle: begin
                // Gated by rst so nothing looks accepted while reset is held.
                if (bus.req_valid != 2'b00 && !rst) begin
                    req_ready[win] = 1'b1;
                    a_d            = win ? bus.req_a1 : bus.req_a0;
                    b_d            = win ? bus.req_b1 : bus.req_b0;
                    id_d           = win;
                    last_grant_d   = win;
                    state_d        = StExec;
                end
            end
            StExec: begin
                sum_d     = {1'b0, a_q} + {1'b0, b_q};
                // resp_id keeps the previous owner until the new result exists.
                resp_id_d = id_q;
                state_d   = StResp;
            end
            StResp: begin
                resp_valid[id_q] = 1'b1;
                if (bus.resp_ready[id_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            id_q         <= 1'b0;
            resp_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            id_q         <= id_d;
            resp_id_q    <= resp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.busy       = (state_q != StIdle);
endmodule
